// File: rtl/uart_io_dev_if.sv
// MIO bus register-access signals for the UART peripheral.
// The CPU side drives the strobes; the peripheral returns registered read data.
interface uart_io_dev_if;
  logic        cs;
  logic        we;
  logic        rd;
  logic [1:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output cs, we, rd, addr, din, input dout);
  modport slave  (input cs, we, rd, addr, din, output dout);
endinterface

// File: rtl/uart_io_dev.sv
// Memory-mapped UART: 16x-oversampled RX/TX, independent FIFOs, programmable
// divisor, loopback, FIFO flush and sticky error flags behind four registers.
module uart_io_dev #(
  parameter int DATA_BITS       = 8,
  parameter int RX_DEPTH        = 16,
  parameter int TX_DEPTH        = 16,
  parameter int DEFAULT_DIVISOR = 52
) (
  input  logic         clk,
  input  logic         clrn,
  uart_io_dev_if.slave bus,
  input  logic         uart_rx,
  output logic         uart_tx,
  output logic         rx_ready,
  output logic         tx_full
);

  localparam int DB  = DATA_BITS;
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic [15:0] DIV_RST  = 16'(DEFAULT_DIVISOR);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} frame_state_t;

  // ---------------------------------------------------------------- bus decode
  logic rd_en, wr_en, data_wr, div_wr, ctrl_wr;
  logic rx_flush, tx_flush, clr_err;
  logic unused_din;

  assign rd_en    = bus.cs & bus.rd & ~bus.we;
  assign wr_en    = bus.cs & bus.we;
  assign data_wr  = wr_en & (bus.addr == 2'd0);
  assign div_wr   = wr_en & (bus.addr == 2'd2);
  assign ctrl_wr  = wr_en & (bus.addr == 2'd3);
  assign rx_flush = ctrl_wr & bus.din[1];
  assign tx_flush = ctrl_wr & bus.din[2];
  assign clr_err  = ctrl_wr & bus.din[3];
  assign unused_din = ^bus.din[31:16];

  // ------------------------------------------------------ baud tick generator
  logic [15:0] div_q, cnt_q, div_m1;
  logic        tick;
  logic        loopback_q;

  assign div_m1 = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
  assign tick   = (cnt_q == 16'd0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      div_q      <= DIV_RST;
      cnt_q      <= DIV_RST - 16'd1;
      loopback_q <= 1'b0;
    end else begin
      if (div_wr) begin
        div_q <= bus.din[15:0];
        cnt_q <= (bus.din[15:0] == 16'd0) ? 16'd0 : bus.din[15:0] - 16'd1;
      end else if (tick) begin
        cnt_q <= div_m1;
      end else begin
        cnt_q <= cnt_q - 16'd1;
      end
      if (ctrl_wr) loopback_q <= bus.din[0];
    end
  end

  // ------------------------------------------------------------------ RX FIFO
  logic [DB-1:0] rx_mem [RX_DEPTH];
  logic [RAW:0]  rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d, rx_count;
  logic          rx_empty_q, rx_full_q, rx_push, rx_pop, rx_push_ok, rx_pop_ok;
  logic [DB-1:0] rx_head, rx_shift_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rx_pop_ok  = rx_pop & ~rx_empty_q;
    rx_push_ok = rx_push & (~rx_full_q | rx_pop_ok);
    rx_wr_d    = rx_wr_q + {{RAW{1'b0}}, rx_push_ok};
    rx_rd_d    = rx_rd_q + {{RAW{1'b0}}, rx_pop_ok};
    if (rx_flush) begin
      rx_wr_d = '0;
      rx_rd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_empty_q <= 1'b1;
      rx_full_q  <= 1'b0;
    end else begin
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_empty_q <= (rx_wr_d == rx_rd_d);
      rx_full_q  <= (rx_wr_d[RAW] != rx_rd_d[RAW]) &&
                    (rx_wr_d[RAW-1:0] == rx_rd_d[RAW-1:0]);
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (rx_push_ok) rx_mem[rx_wr_q[RAW-1:0]] <= rx_shift_q;
  end

  assign rx_head  = rx_mem[rx_rd_q[RAW-1:0]];
  assign rx_count = rx_wr_q - rx_rd_q;

  // ------------------------------------------------------------------ TX FIFO
  logic [DB-1:0] tx_mem [TX_DEPTH];
  logic [TAW:0]  tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, tx_count;
  logic          tx_empty_q, tx_full_q, tx_pop, tx_push_ok, tx_pop_ok;
  logic [DB-1:0] tx_head;

  always_comb begin
    tx_pop_ok  = tx_pop & ~tx_empty_q;
    tx_push_ok = data_wr & (~tx_full_q | tx_pop_ok);
    tx_wr_d    = tx_wr_q + {{TAW{1'b0}}, tx_push_ok};
    tx_rd_d    = tx_rd_q + {{TAW{1'b0}}, tx_pop_ok};
    if (tx_flush) begin
      tx_wr_d = '0;
      tx_rd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_empty_q <= 1'b1;
      tx_full_q  <= 1'b0;
    end else begin
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_empty_q <= (tx_wr_d == tx_rd_d);
      tx_full_q  <= (tx_wr_d[TAW] != tx_rd_d[TAW]) &&
                    (tx_wr_d[TAW-1:0] == tx_rd_d[TAW-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem[tx_wr_q[TAW-1:0]] <= bus.din[DB-1:0];
  end

  assign tx_head  = tx_mem[tx_rd_q[TAW-1:0]];
  assign tx_count = tx_wr_q - tx_rd_q;

  // --------------------------------------------------------------- RX FSM
  frame_state_t rx_state_q;
  logic [3:0]   rx_tick_q, rx_bit_q;
  logic [1:0]   sync_q;
  logic         rx_prev_q, rx_in, rx_stop_sample, tx_q;

  assign rx_in          = loopback_q ? tx_q : sync_q[1];
  assign rx_stop_sample = tick & (rx_state_q == S_STOP) & (rx_tick_q == 4'd15);
  assign rx_push        = rx_stop_sample & rx_in;
  assign rx_pop         = rd_en & (bus.addr == 2'd0);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      sync_q    <= {sync_q[0], uart_rx};
      rx_prev_q <= rx_in;
      unique case (rx_state_q)
        S_IDLE: if (rx_prev_q && !rx_in) begin
          rx_state_q <= S_START;
          rx_tick_q  <= '0;
        end
        S_START: if (tick) begin
          // Mid-start-bit check rejects glitches shorter than half a bit.
          if (rx_tick_q == 4'd7) begin
            rx_state_q <= rx_in ? S_IDLE : S_DATA;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
          end else begin
            rx_tick_q <= rx_tick_q + 4'd1;
          end
        end
        S_DATA: if (tick) begin
          if (rx_tick_q == 4'd15) begin
            rx_tick_q  <= '0;
            rx_shift_q <= {rx_in, rx_shift_q[DB-1:1]};
            if (rx_bit_q == LAST_BIT) rx_state_q <= S_STOP;
            else                      rx_bit_q   <= rx_bit_q + 4'd1;
          end else begin
            rx_tick_q <= rx_tick_q + 4'd1;
          end
        end
        S_STOP: if (tick) begin
          if (rx_tick_q == 4'd15) begin
            rx_state_q <= S_IDLE;
            rx_tick_q  <= '0;
          end else begin
            rx_tick_q <= rx_tick_q + 4'd1;
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------- TX FSM
  frame_state_t tx_state_q;
  logic [3:0]   tx_tick_q, tx_bit_q;
  logic [DB-1:0] tx_shift_q;

  // A frame is started from IDLE, or straight out of the last stop tick so
  // back-to-back frames carry no idle gap.
  assign tx_pop = tick & ~tx_empty_q &
                  ((tx_state_q == S_IDLE) ||
                   ((tx_state_q == S_STOP) && (tx_tick_q == 4'd15)));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      tx_state_q <= S_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      unique case (tx_state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (tx_pop) begin
            tx_state_q <= S_START;
            tx_tick_q  <= '0;
            tx_shift_q <= tx_head;
            tx_q       <= 1'b0;
          end
        end
        S_START: if (tick) begin
          if (tx_tick_q == 4'd15) begin
            tx_state_q <= S_DATA;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[DB-1:1]};
          end else begin
            tx_tick_q <= tx_tick_q + 4'd1;
          end
        end
        S_DATA: if (tick) begin
          if (tx_tick_q == 4'd15) begin
            tx_tick_q <= '0;
            if (tx_bit_q == LAST_BIT) begin
              tx_state_q <= S_STOP;
              tx_q       <= 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 4'd1;
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[DB-1:1]};
            end
          end else begin
            tx_tick_q <= tx_tick_q + 4'd1;
          end
        end
        S_STOP: if (tick) begin
          if (tx_tick_q == 4'd15) begin
            tx_tick_q <= '0;
            if (tx_pop) begin
              tx_state_q <= S_START;
              tx_shift_q <= tx_head;
              tx_q       <= 1'b0;
            end else begin
              tx_state_q <= S_IDLE;
            end
          end else begin
            tx_tick_q <= tx_tick_q + 4'd1;
          end
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  // ------------------------------------------------ sticky flags and read port
  logic        rx_ovr_q, frame_err_q, tx_ovf_q;
  logic [31:0] dout_q, status;

  assign status = {8'd0, 8'(tx_count), 8'(rx_count), 2'b00,
                   tx_ovf_q, frame_err_q, rx_ovr_q,
                   tx_empty_q & (tx_state_q == S_IDLE), tx_full_q, ~rx_empty_q};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      tx_ovf_q    <= 1'b0;
      dout_q      <= '0;
    end else begin
      // A new error in the same cycle as clear_err still sets its flag.
      rx_ovr_q    <= (rx_ovr_q    & ~clr_err) | (rx_push & ~rx_push_ok);
      frame_err_q <= (frame_err_q & ~clr_err) | (rx_stop_sample & ~rx_in);
      tx_ovf_q    <= (tx_ovf_q    & ~clr_err) | (data_wr & ~tx_push_ok);
      if (rd_en) begin
        unique case (bus.addr)
          2'd0: dout_q <= rx_empty_q ? 32'd0 : 32'(rx_head);
          2'd1: dout_q <= status;
          2'd2: dout_q <= {16'd0, div_q};
          2'd3: dout_q <= {31'd0, loopback_q};
          default: dout_q <= '0;
        endcase
      end
    end
  end

  assign bus.dout = dout_q;
  assign uart_tx  = tx_q;
  assign rx_ready = ~rx_empty_q;
  assign tx_full  = tx_full_q;

endmodule
